// File: rtl/add_sub_pkg.sv
// Shared encodings and saturation-limit helpers for the add_sub arithmetic slice.
// The saturation helpers are only referenced when ADD_SUB_SAT_EN is defined.
package add_sub_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Widest operand the saturation helpers can describe.
   localparam int MAX_W = 64;

   // 0 followed by w-1 ones: the largest positive value in w bits.
   function automatic logic [MAX_W-1:0] sat_max(input int w);
      return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
   endfunction

   // 1 followed by w-1 zeros: the most negative value in w bits.
   function automatic logic [MAX_W-1:0] sat_min(input int w);
      return MAX_W'(1) << (w - 1);
   endfunction

endpackage

// File: rtl/add_sub_full_adder.sv
// Single-bit full adder; one stage of the add_sub ripple-carry chain.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/add_sub.sv
// W-bit signed adder/subtractor with registered result, overflow and carry-out.
// Define ADD_SUB_SAT_EN to clamp the result to the signed limits on overflow.
module add_sub
   import add_sub_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   input  logic         c0,
   output logic [W-1:0] R,
   output logic         ovf,
   output logic         cout
);

   logic [W-1:0] bx;
   logic [W-1:0] sum;
   logic [W:0]   c;
   logic         ovf_next;
   logic [W-1:0] r_next;

   // Subtraction is A + ~B + 1; c0 supplies both the inversion and the +1.
   assign bx   = B ^ {W{c0}};
   assign c[0] = c0;

   for (genvar i = 0; i < W; i++) begin : g_chain
      full_adder u_fa (
         .a  (A[i]),
         .b  (bx[i]),
         .ci (c[i]),
         .s  (sum[i]),
         .co (c[i+1])
      );
   end

   assign ovf_next = c[W] ^ c[W-1];

`ifdef ADD_SUB_SAT_EN
   localparam logic [MAX_W-1:0] SAT_MAX_FULL = sat_max(W);
   localparam logic [MAX_W-1:0] SAT_MIN_FULL = sat_min(W);
   localparam logic [W-1:0]     SAT_MAX      = SAT_MAX_FULL[W-1:0];
   localparam logic [W-1:0]     SAT_MIN      = SAT_MIN_FULL[W-1:0];

   // On overflow the true result has the sign of A, so clamp toward that side.
   always_comb begin
      r_next = sum;
      if (ovf_next) begin
         r_next = A[W-1] ? SAT_MIN : SAT_MAX;
      end
   end
`else
   assign r_next = sum;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         R    <= '0;
         ovf  <= 1'b0;
         cout <= 1'b0;
      end else begin
         R    <= r_next;
         ovf  <= ovf_next;
         cout <= c[W];
      end
   end

endmodule

// File: tb/tb_add_sub.sv
// Directed, table-driven check of add_sub at W=4, plus hand-written reset sequences.
// Expected saturated results are selected when ADD_SUB_SAT_EN is defined.
module tb_add_sub;
   import add_sub_pkg::*;

   localparam int W = 4;

   logic         clk;
   logic         rst;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         c0;
   logic [W-1:0] r;
   logic         ovf;
   logic         cout;

   int n_cmp;
   int n_bad;

   typedef struct {
      string        name;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         c0;
      logic [W-1:0] r_wrap;
      logic [W-1:0] r_sat;
      logic         ovf;
      logic         cout;
   } vec_t;

   localparam int NV = 15;
   vec_t vecs[NV];

   add_sub #(.W(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .A    (a),
      .B    (b),
      .c0   (c0),
      .R    (r),
      .ovf  (ovf),
      .cout (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic vec_t mk(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                               input logic vc0, input logic [W-1:0] vr, input logic [W-1:0] vrs,
                               input logic vovf, input logic vcout);
      vec_t v;
      v.name = name; v.a = va; v.b = vb; v.c0 = vc0;
      v.r_wrap = vr; v.r_sat = vrs; v.ovf = vovf; v.cout = vcout;
      return v;
   endfunction

   initial begin
      n_cmp = 0;
      n_bad = 0;
      //                name          A      B      c0      R_wrap R_sat  ovf   cout
      vecs[0]  = mk("add_4p3",      4'h4, 4'h3, OP_ADD, 4'h7, 4'h7, 1'b0, 1'b0);
      vecs[1]  = mk("add_7p1",      4'h7, 4'h1, OP_ADD, 4'h8, 4'h7, 1'b1, 1'b0);
      vecs[2]  = mk("add_m7pm1",    4'h9, 4'hF, OP_ADD, 4'h8, 4'h8, 1'b0, 1'b1);
      vecs[3]  = mk("add_m8pm8",    4'h8, 4'h8, OP_ADD, 4'h0, 4'h8, 1'b1, 1'b1);
      vecs[4]  = mk("sub_5m2",      4'h5, 4'h2, OP_SUB, 4'h3, 4'h3, 1'b0, 1'b1);
      vecs[5]  = mk("sub_m5mm2",    4'hB, 4'hE, OP_SUB, 4'hD, 4'hD, 1'b0, 1'b0);
      vecs[6]  = mk("sub_2m2",      4'h2, 4'h2, OP_SUB, 4'h0, 4'h0, 1'b0, 1'b1);
      vecs[7]  = mk("sub_7mm2",     4'h7, 4'hE, OP_SUB, 4'h9, 4'h7, 1'b1, 1'b0);
      vecs[8]  = mk("sub_m8m1",     4'h8, 4'h1, OP_SUB, 4'h7, 4'h8, 1'b1, 1'b1);
      vecs[9]  = mk("add_0p0",      4'h0, 4'h0, OP_ADD, 4'h0, 4'h0, 1'b0, 1'b0);
      vecs[10] = mk("sub_0m0",      4'h0, 4'h0, OP_SUB, 4'h0, 4'h0, 1'b0, 1'b1);
      vecs[11] = mk("add_m1p1",     4'hF, 4'h1, OP_ADD, 4'h0, 4'h0, 1'b0, 1'b1);
      vecs[12] = mk("sub_3m5",      4'h3, 4'h5, OP_SUB, 4'hE, 4'hE, 1'b0, 1'b0);
      vecs[13] = mk("sub_m8mm8",    4'h8, 4'h8, OP_SUB, 4'h0, 4'h0, 1'b0, 1'b1);
      vecs[14] = mk("add_7p7",      4'h7, 4'h7, OP_ADD, 4'hE, 4'h7, 1'b1, 1'b0);

      rst = 1'b1;
      a = 4'h5; b = 4'h6; c0 = OP_ADD;
      repeat (2) @(posedge clk);
      #1;
      check("reset_r", 32'(r), 32'h0);
      check("reset_ovf", 32'(ovf), 32'h0);
      check("reset_cout", 32'(cout), 32'h0);

      @(negedge clk);
      rst = 1'b0;
      // Back-to-back vectors: each result must appear right after the edge that samples it.
      for (int i = 0; i < NV; i++) begin
         a = vecs[i].a; b = vecs[i].b; c0 = vecs[i].c0;
         @(posedge clk);
         #1;
`ifdef ADD_SUB_SAT_EN
         check({vecs[i].name, "_r"}, 32'(r), 32'(vecs[i].r_sat));
`else
         check({vecs[i].name, "_r"}, 32'(r), 32'(vecs[i].r_wrap));
`endif
         check({vecs[i].name, "_ovf"}, 32'(ovf), 32'(vecs[i].ovf));
         check({vecs[i].name, "_cout"}, 32'(cout), 32'(vecs[i].cout));
         @(negedge clk);
      end

      // Result holds until the next edge even though inputs change mid-cycle.
      a = 4'h4; b = 4'h3; c0 = OP_ADD;
      @(posedge clk);
      #1;
      check("hold_pre_r", 32'(r), 32'h7);
      a = 4'h5; b = 4'h2; c0 = OP_SUB;
      #3;
      check("hold_mid_r", 32'(r), 32'h7);
      check("hold_mid_cout", 32'(cout), 32'h0);

      // Asynchronous reset between edges with an overflowing result registered.
      @(negedge clk);
      a = 4'h7; b = 4'h1; c0 = OP_ADD;
      @(posedge clk);
      #1;
      check("pre_rst_ovf", 32'(ovf), 32'h1);
      #1;
      rst = 1'b1;
      #1;
      check("async_rst_r", 32'(r), 32'h0);
      check("async_rst_ovf", 32'(ovf), 32'h0);
      check("async_rst_cout", 32'(cout), 32'h0);
      @(posedge clk);
      #1;
      check("rst_held_r", 32'(r), 32'h0);

      // Release mid-cycle: nothing changes until the next rising edge loads 5-2.
      @(negedge clk);
      a = 4'h5; b = 4'h2; c0 = OP_SUB;
      rst = 1'b0;
      #2;
      check("post_rel_r", 32'(r), 32'h0);
      check("post_rel_cout", 32'(cout), 32'h0);
      @(posedge clk);
      #1;
      check("first_edge_r", 32'(r), 32'h3);
      check("first_edge_ovf", 32'(ovf), 32'h0);
      check("first_edge_cout", 32'(cout), 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
